// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The optional checksum stage is enabled by defining LOADER_CSUM_EN.
package loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCheck,
      StRelease,
      StRun,
      StError
   } state_e;

   localparam int unsigned DATA_W       = 32;
   localparam int unsigned RST_HOLD_DEF = 4;

endpackage

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, then releases the core from reset.
// Define LOADER_CSUM_EN to require a trailing modulo-2**32 checksum word before release.
module imem_loader
   import loader_pkg::*;
#(
   parameter int unsigned RST_HOLD = RST_HOLD_DEF,
   parameter int unsigned ADDR_W   = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_start,
   input  logic [ADDR_W:0]   ld_len,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              core_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] MaxLen   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CntOne   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [3:0]      HoldLast = 4'(RST_HOLD - 1);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [3:0]        hold_q, hold_d;
   logic              core_rst_q;
   logic [ADDR_W:0]   cnt_inc;
   logic              len_legal;
`ifdef LOADER_CSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
`endif

   assign cnt_inc   = cnt_q + CntOne;
   assign len_legal = (ld_len != '0) && (ld_len <= MaxLen);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      hold_d  = hold_q;
      s_ready = 1'b0;
      mem_we  = 1'b0;
`ifdef LOADER_CSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         StIdle, StRun, StError: begin
            if (ld_start) begin
               if (len_legal) begin
                  state_d = StLoad;
                  len_d   = ld_len;
                  cnt_d   = '0;
`ifdef LOADER_CSUM_EN
                  csum_d  = '0;
`endif
               end else begin
                  state_d = StError;
               end
            end
         end
         StLoad: begin
            s_ready = 1'b1;
            if (s_valid) begin
               mem_we = 1'b1;
               cnt_d  = cnt_inc;
`ifdef LOADER_CSUM_EN
               csum_d = csum_q + s_data;
`endif
               if (cnt_inc == len_q) begin
                  hold_d = '0;
`ifdef LOADER_CSUM_EN
                  state_d = StCheck;
`else
                  state_d = StRelease;
`endif
               end
            end
         end
`ifdef LOADER_CSUM_EN
         StCheck: begin
            // Checksum beat is consumed but never written to memory.
            s_ready = 1'b1;
            if (s_valid) begin
               hold_d  = '0;
               state_d = (s_data == csum_q) ? StRelease : StError;
            end
         end
`endif
         StRelease: begin
            if (hold_q == HoldLast) begin
               state_d = StRun;
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         len_q      <= '0;
         hold_q     <= '0;
         core_rst_q <= 1'b0;
`ifdef LOADER_CSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         hold_q     <= hold_d;
         // Registered from next state so the core reset rises on the edge entering RUN.
         core_rst_q <= (state_d == StRun);
`ifdef LOADER_CSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign mem_addr   = cnt_q[ADDR_W-1:0];
   assign mem_wdata  = s_data;
   assign core_rst_n = core_rst_q;
   assign busy       = (state_q == StLoad) || (state_q == StCheck) || (state_q == StRelease);
   assign done       = (state_q == StRun);
   assign err        = (state_q == StError);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table plus multi-cycle corner sequences.
// Checksum-specific beats are included when LOADER_CSUM_EN is defined.
module tb_imem_loader;

   localparam int unsigned ADDR_W = 12;

   logic        clk;
   logic        rst_n;
   logic        ld_start;
   logic [12:0] ld_len;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        core_rst_n;
   logic        busy;
   logic        done;
   logic        err;

   imem_loader #(.RST_HOLD(4), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld_start   (ld_start),
      .ld_len     (ld_len),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .core_rst_n (core_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic [12:0] len;
      logic        valid;
      logic [31:0] data;
      logic        ready;
      logic        we;
      logic [11:0] addr;
      logic        crst;
      logic        busy;
      logic        done;
      logic        err;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic void add(input logic st, input logic [12:0] len, input logic vld,
                               input logic [31:0] d, input logic rdy, input logic we,
                               input logic [11:0] a, input logic crst, input logic bsy,
                               input logic dn, input logic er);
      vec_t v;
      v.start = st;  v.len = len;   v.valid = vld; v.data = d;
      v.ready = rdy; v.we = we;     v.addr = a;    v.crst = crst;
      v.busy = bsy;  v.done = dn;   v.err = er;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic [12:0] len, input logic vld,
                        input logic [31:0] d);
      @(negedge clk);
      ld_start = st;
      ld_len   = len;
      s_valid  = vld;
      s_data   = d;
      #1;
   endtask

   task automatic chk_out(input string tag, input logic rdy, input logic we, input logic crst,
                          input logic bsy, input logic dn, input logic er);
      chk({tag, ".s_ready"}, {31'd0, s_ready}, {31'd0, rdy});
      chk({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, we});
      chk({tag, ".core_rst_n"}, {31'd0, core_rst_n}, {31'd0, crst});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
      chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
      chk({tag, ".err"}, {31'd0, err}, {31'd0, er});
   endtask

   task automatic release_and_run(input string tag);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 13'd0, 1'b1, 32'hBAD0_0000);
         chk_out($sformatf("%s.rel%0d", tag, i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      drive(1'b0, 13'd0, 1'b0, 32'd0);
      chk_out({tag, ".run"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [31:0] sum;

      rst_n = 1'b0; ld_start = 1'b0; ld_len = '0; s_valid = 1'b0; s_data = '0;
      #2;
      chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // len=3 back-to-back
      add(0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0);
      add(1, 3, 0, 0,        0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 32'h11,   1, 1, 0, 0, 1, 0, 0);
      add(0, 0, 1, 32'h22,   1, 1, 1, 0, 1, 0, 0);
      add(0, 0, 1, 32'h33,   1, 1, 2, 0, 1, 0, 0);
`ifdef LOADER_CSUM_EN
      add(0, 0, 1, 32'h66,   1, 0, 0, 0, 1, 0, 0);
`endif
      for (int i = 0; i < 4; i++) add(0, 0, 1, 32'h44, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0,        0, 0, 0, 1, 0, 1, 0);
      // len=2 with 5-cycle gap, started from RUN
      add(1, 2, 0, 0,        0, 0, 0, 1, 0, 1, 0);
      add(0, 0, 0, 0,        1, 0, 0, 0, 1, 0, 0);
      add(0, 0, 1, 32'hA,    1, 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
      add(0, 0, 1, 32'hB,    1, 1, 1, 0, 1, 0, 0);
`ifdef LOADER_CSUM_EN
      add(0, 0, 1, 32'h15,   1, 0, 0, 0, 1, 0, 0);
`endif
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0,        0, 0, 0, 1, 0, 1, 0);
      // len=0 -> ERROR, then legal len=1 recovers
      add(1, 0, 0, 0,        0, 0, 0, 1, 0, 1, 0);
      add(0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 1);
      add(1, 1, 0, 0,        0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0,        1, 0, 0, 0, 1, 0, 0);
      add(0, 0, 1, 32'hC,    1, 1, 0, 0, 1, 0, 0);
`ifdef LOADER_CSUM_EN
      add(0, 0, 1, 32'hC,    1, 0, 0, 0, 1, 0, 0);
`endif
      add(1, 2, 0, 0,        0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0,        0, 0, 0, 1, 0, 1, 0);
      // len > depth -> ERROR
      add(1, 4097, 0, 0,     0, 0, 0, 1, 0, 1, 0);
      add(0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].start, tbl[i].len, tbl[i].valid, tbl[i].data);
         chk_out($sformatf("vec%0d", i), tbl[i].ready, tbl[i].we, tbl[i].crst,
                 tbl[i].busy, tbl[i].done, tbl[i].err);
         if (tbl[i].we) begin
            chk($sformatf("vec%0d.mem_addr", i), {20'd0, mem_addr}, {20'd0, tbl[i].addr});
            chk($sformatf("vec%0d.mem_wdata", i), mem_wdata, tbl[i].data);
         end
      end

      // Full-depth load from ERROR: last write at 0xFFF, no wrap write
      drive(1'b1, 13'd4096, 1'b0, 32'd0);
      sum = '0;
      for (int i = 0; i < 4096; i++) begin
         drive(1'b0, 13'd0, 1'b1, 32'(i) ^ 32'h5A00_0000);
         sum = sum + (32'(i) ^ 32'h5A00_0000);
         if (i == 0 || i == 4095 || (i % 1024) == 511) begin
            chk($sformatf("full%0d.mem_we", i), {31'd0, mem_we}, 32'd1);
            chk($sformatf("full%0d.mem_addr", i), {20'd0, mem_addr}, 32'(i));
         end
      end
`ifdef LOADER_CSUM_EN
      drive(1'b0, 13'd0, 1'b1, sum);
      chk("full.csum_we", {31'd0, mem_we}, 32'd0);
`endif
      release_and_run("full");

`ifdef LOADER_CSUM_EN
      // Wrong checksum -> ERROR with core held in reset
      drive(1'b1, 13'd2, 1'b0, 32'd0);
      drive(1'b0, 13'd0, 1'b1, 32'h1);
      drive(1'b0, 13'd0, 1'b1, 32'h2);
      drive(1'b0, 13'd0, 1'b1, 32'h4);
      chk_out("badsum.check", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 13'd0, 1'b0, 32'd0);
      chk_out("badsum.err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

      // Asynchronous reset mid-load after 2 of 5 beats
      drive(1'b1, 13'd5, 1'b0, 32'd0);
      drive(1'b0, 13'd0, 1'b1, 32'h100);
      drive(1'b0, 13'd0, 1'b1, 32'h101);
      drive(1'b0, 13'd0, 1'b1, 32'h102);
      chk("midrst.pre_addr", {20'd0, mem_addr}, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk_out("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 13'd0, 1'b1, 32'h103);
      chk_out("midrst.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reload from RUN: core reset drops on the next edge, counter restarts at 0
      drive(1'b1, 13'd1, 1'b0, 32'd0);
      drive(1'b0, 13'd0, 1'b1, 32'h77);
      chk("reload1.addr", {20'd0, mem_addr}, 32'd0);
`ifdef LOADER_CSUM_EN
      drive(1'b0, 13'd0, 1'b1, 32'h77);
`endif
      release_and_run("reload1");
      drive(1'b1, 13'd2, 1'b0, 32'd0);
      chk("reload2.pre_crst", {31'd0, core_rst_n}, 32'd1);
      drive(1'b0, 13'd0, 1'b1, 32'h88);
      chk_out("reload2.load", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("reload2.addr", {20'd0, mem_addr}, 32'd0);
      drive(1'b0, 13'd0, 1'b1, 32'h99);
      chk("reload2.addr1", {20'd0, mem_addr}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter RST_HOLD, default 4, number of cycles core_rst_n stays low after a successful load before release (legal range 2..15).
REQ-002 Parameter ADDR_W, default 12, instruction memory address width; depth is 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ld_start  input  1  one-cycle request to begin a program load.
REQ-006 ld_len  input  ADDR_W+1  number of program words to load, sampled when ld_start is accepted.
REQ-007 s_valid  input  1  upstream word valid.
REQ-008 s_data  input  32  upstream program word.
REQ-009 s_ready  output  1  loader accepts s_data this cycle.
REQ-010 mem_we  output  1  instruction memory write enable.
REQ-011 mem_addr  output  ADDR_W  instruction memory word address.
REQ-012 mem_wdata  output  32  instruction memory write data.
REQ-013 core_rst_n  output  1  active-low reset to the core; registered, glitch-free.
REQ-014 busy  output  1  high in LOAD, CHECK, RELEASE.
REQ-015 done  output  1  high in RUN.
REQ-016 err  output  1  high in ERROR.

Function
REQ-017 States SHALL be IDLE, LOAD, CHECK, RELEASE, RUN, ERROR.
REQ-018 A beat SHALL occur when s_valid and s_ready are both high; s_ready SHALL be high only in LOAD and CHECK.
REQ-019 In LOAD each beat SHALL drive mem_we=1, mem_addr=word counter, mem_wdata=s_data in the same cycle (zero latency, combinational from s_data/s_valid), then increment the counter.
REQ-020 ld_start in IDLE, RUN or ERROR with 1 <= ld_len <= 2**ADDR_W SHALL latch ld_len, clear counter, and enter LOAD next cycle; core_rst_n SHALL be low from that edge.
REQ-021 ld_start with ld_len=0 or ld_len > 2**ADDR_W SHALL enter ERROR.
REQ-022 ld_start in LOAD, CHECK or RELEASE SHALL be ignored.
REQ-023 The beat writing word ld_len-1 SHALL move LOAD to CHECK (feature enabled) or RELEASE (disabled); ld_len=2**ADDR_W writes address 2**ADDR_W-1 last, with no counter wrap to 0 being written.
REQ-024 Absent s_valid, LOAD SHALL wait indefinitely with mem_we=0; no timeout.
REQ-025 RELEASE SHALL hold core_rst_n low for exactly RST_HOLD cycles, then enter RUN; core_rst_n SHALL rise on the edge entering RUN.
REQ-026 ERROR SHALL hold core_rst_n low and err high until a legal ld_start; err SHALL clear on the edge entering LOAD.
REQ-027 mem_we SHALL be 0 in every state except LOAD.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, counters 0, checksum 0, core_rst_n=0, s_ready=0, mem_we=0, busy=0, done=0, err=0.
REQ-029 Reset during LOAD SHALL abandon the load; partially written memory is not restored.

Configuration
REQ-030 With LOADER_CSUM_EN defined, LOAD SHALL accumulate a 32-bit modulo-2**32 sum of written words, and CHECK SHALL accept one further beat: equal to sum -> RELEASE, otherwise -> ERROR; that word SHALL NOT be written to memory.
REQ-031 Without LOADER_CSUM_EN, CHECK and the accumulator SHALL not exist and LOAD SHALL proceed directly to RELEASE.

Structure
REQ-032 Package loader_pkg SHALL hold the state enum typedef, DATA_W=32 and the RST_HOLD default constant.
REQ-033 Single module; no sub-module required.

Verification
REQ-034 ld_start, ld_len=3, words 0x11,0x22,0x33 back-to-back -> writes addr 0..2, RELEASE 4 cycles, core_rst_n=1, done=1.
REQ-035 ld_len=2 with s_valid gapped 5 idle cycles between beats -> mem_we only on beats, addr 0 then 1, no extra writes.
REQ-036 LOADER_CSUM_EN, words 0x1,0x2 then checksum 0x3 -> RUN; repeat with checksum 0x4 -> ERROR, err=1, core_rst_n=0.
REQ-037 ld_len=0 -> ERROR; then legal ld_start ld_len=1 -> err=0, LOAD.
REQ-038 ld_len=4096 -> last write at addr 0xFFF, then RELEASE.
REQ-039 rst_n asserted mid-LOAD after 2 of 5 beats -> all outputs at reset values asynchronously; ld_start in RUN -> core_rst_n low next edge, reload proceeds.
